pwm_dac_streamer: RTL and testbench

- Playback direction of the PWM SAR converter: accepts a stream of unsigned digital samples over a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample to a PWM duty cycle. Each sample is held for a fixed number of PWM periods.
- pwm_out drives the same RC filter / analog front end used by the ADC path, forming the board's DAC output.
- Reports FIFO level, a per-sample strobe, and sticky underflow.

---
 rtl/pwm_dac_streamer.sv | 148 ++++++++++++++
 tb/tb_pwm_dac_streamer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_streamer.sv
// PWM DAC playback streamer: buffers unsigned samples in a small FIFO and plays
// each one out as a PWM duty cycle held for PERIODS_PER_SAMPLE PWM periods.
module pwm_dac_streamer #(
    parameter int unsigned WIDTH              = 8,
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned PERIODS_PER_SAMPLE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          pwm_out,
    output logic                          sample_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    input  logic                          clear_underflow,
    output logic                          busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] pwm_cnt_q;
    logic [PW-1:0]    period_cnt_q;
    logic             pwm_q;
    logic             strobe_q;
    logic             underflow_q;

    logic fifo_empty;
    logic push;
    logic pop;
    logic boundary;
    logic set_underflow;

    // Full/empty come straight from the registered level, so a pop never frees a
    // slot for a push in the same cycle.
    assign s_ready       = (level_q != LW'(FIFO_DEPTH));
    assign fifo_empty    = (level_q == '0);
    assign push          = s_valid && s_ready;
    assign boundary      = (pwm_cnt_q == '1) && (period_cnt_q == PW'(PERIODS_PER_SAMPLE - 1));
    assign pop           = en && !fifo_empty &&
                           ((state_q == StPrime) || ((state_q == StRun) && boundary));
    assign set_underflow = en && (state_q == StRun) && boundary && fifo_empty;

    assign pwm_out       = pwm_q;
    assign sample_strobe = strobe_q;
    assign fifo_level    = level_q;
    assign underflow     = underflow_q;
    assign busy          = (state_q == StRun);

    // Sample storage; contents need no reset since level/pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    // Playback FSM with PWM/period counters, duty register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            duty_q       <= '0;
            pwm_cnt_q    <= '0;
            period_cnt_q <= '0;
            pwm_q        <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            // Compare uses pre-edge state/counter, so the output lags the counter by one.
            pwm_q    <= (state_q == StRun) && (pwm_cnt_q < duty_q);
            if (!en) begin
                state_q      <= StIdle;
                duty_q       <= '0;
                pwm_cnt_q    <= '0;
                period_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q      <= StPrime;
                        duty_q       <= '0;
                        pwm_cnt_q    <= '0;
                        period_cnt_q <= '0;
                    end
                    StPrime: begin
                        pwm_cnt_q    <= '0;
                        period_cnt_q <= '0;
                        if (!fifo_empty) begin
                            duty_q   <= mem_q[rd_ptr_q];
                            strobe_q <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                    StRun: begin
                        pwm_cnt_q <= pwm_cnt_q + WIDTH'(1);
                        if (pwm_cnt_q == '1) begin
                            if (period_cnt_q == PW'(PERIODS_PER_SAMPLE - 1)) begin
                                period_cnt_q <= '0;
                            end else begin
                                period_cnt_q <= period_cnt_q + PW'(1);
                            end
                        end
                        // Empty boundary keeps the current duty; underflow is flagged separately.
                        if (boundary && !fifo_empty) begin
                            duty_q   <= mem_q[rd_ptr_q];
                            strobe_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Sticky underflow; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else if (set_underflow) begin
            underflow_q <= 1'b1;
        end else if (clear_underflow) begin
            underflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_dac_streamer.sv
// Directed bench for pwm_dac_streamer (default parameters: 8-bit, depth 8, 4 periods).
module tb_pwm_dac_streamer;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       pwm_out;
    logic       sample_strobe;
    logic [3:0] fifo_level;
    logic       underflow;
    logic       clear_underflow;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_dac_streamer #(
        .WIDTH(8),
        .FIFO_DEPTH(8),
        .PERIODS_PER_SAMPLE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .pwm_out(pwm_out),
        .sample_strobe(sample_strobe),
        .fifo_level(fifo_level),
        .underflow(underflow),
        .clear_underflow(clear_underflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " pwm_out"}, int'(pwm_out), 0);
        check_eq({tag, " s_ready"}, int'(s_ready), 1);
        check_eq({tag, " fifo_level"}, int'(fifo_level), 0);
        check_eq({tag, " underflow"}, int'(underflow), 0);
        check_eq({tag, " busy"}, int'(busy), 0);
        check_eq({tag, " sample_strobe"}, int'(sample_strobe), 0);
    endtask

    // Counts negedges until sample_strobe is seen, giving up after limit.
    task automatic wait_strobe(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!sample_strobe && cycles < limit);
        if (!sample_strobe) cycles = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi [4];
        int highs;
        int strobes;
        int cyc;
        int win_hi [10];
        int exp_duty [10];
        int bad_strobe;
        int good_strobe;

        reset = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; clear_underflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");

        // Single sample 0x40 pushed while in PRIME.
        reset = 1'b0;
        en = 1'b1;
        @(negedge clk);
        check_eq("prime busy", int'(busy), 0);
        s_valid = 1'b1; s_data = 8'h40;
        @(negedge clk);
        s_valid = 1'b0;
        check_eq("push strobe early", int'(sample_strobe), 0);
        check_eq("push level", int'(fifo_level), 1);
        @(negedge clk);
        check_eq("prime strobe", int'(sample_strobe), 1);
        check_eq("run busy", int'(busy), 1);
        check_eq("prime pop level", int'(fifo_level), 0);
        for (int k = 0; k < 4; k++) hi[k] = 0;
        strobes = 0;
        for (int j = 1; j <= 1024; j++) begin
            @(negedge clk);
            hi[(j - 1) / 256] += int'(pwm_out);
            strobes += int'(sample_strobe);
            if (j == 1) check_eq("first pwm high", int'(pwm_out), 1);
            if (j == 1023) check_eq("underflow before boundary", int'(underflow), 0);
        end
        for (int k = 0; k < 4; k++) check_eq($sformatf("duty40 period%0d highs", k), hi[k], 64);
        check_eq("duty40 no extra strobe", strobes, 0);
        check_eq("empty boundary underflow", int'(underflow), 1);
        highs = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            highs += int'(pwm_out);
        end
        check_eq("duty40 held highs", highs, 64);

        // Clear, then clear coinciding with an empty boundary (set wins).
        clear_underflow = 1'b1;
        @(negedge clk);
        clear_underflow = 1'b0;
        check_eq("clear underflow", int'(underflow), 0);
        wait_neg(766);
        check_eq("underflow still clear", int'(underflow), 0);
        clear_underflow = 1'b1;
        @(negedge clk);
        clear_underflow = 1'b0;
        check_eq("set beats clear", int'(underflow), 1);

        // Disable and fill: nine back-to-back pushes, the ninth refused.
        en = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) @(negedge clk);
            check_eq($sformatf("s_ready before push %0d", i), int'(s_ready), (i == 9) ? 0 : 1);
            s_valid = 1'b1;
            s_data = 8'(i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check_eq("full level", int'(fifo_level), 8);
        check_eq("full s_ready", int'(s_ready), 0);
        check_eq("idle busy", int'(busy), 0);
        check_eq("idle pwm", int'(pwm_out), 0);
        clear_underflow = 1'b1;
        @(negedge clk);
        clear_underflow = 1'b0;
        check_eq("idle clear underflow", int'(underflow), 0);

        // Playback of 0x01..0x08, then a 0x00 and 0xFF pushed around the 8th boundary.
        en = 1'b1;
        wait_strobe(10, cyc);
        check_eq("enable to first strobe", cyc, 2);
        check_eq("level after first pop", int'(fifo_level), 7);
        exp_duty = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 255};
        for (int w = 0; w < 10; w++) win_hi[w] = 0;
        bad_strobe = 0;
        good_strobe = 0;
        for (int j = 1; j <= 10240; j++) begin
            @(negedge clk);
            win_hi[(j - 1) / 1024] += int'(pwm_out);
            if (sample_strobe) begin
                if ((j % 1024 == 0) && (j <= 9216)) good_strobe++;
                else bad_strobe++;
            end
            if (j == 8190) begin
                check_eq("underflow before refill", int'(underflow), 0);
                check_eq("level drained", int'(fifo_level), 0);
                s_valid = 1'b1; s_data = 8'h00;
            end
            if (j == 8191) begin
                check_eq("level before push+pop", int'(fifo_level), 1);
                s_data = 8'hFF;
            end
            if (j == 8192) begin
                s_valid = 1'b0;
                check_eq("push+pop level", int'(fifo_level), 1);
            end
        end
        for (int w = 0; w < 10; w++) begin
            check_eq($sformatf("window%0d duty%0d highs", w, exp_duty[w]), win_hi[w],
                     4 * exp_duty[w]);
        end
        check_eq("strobes on boundaries", good_strobe, 9);
        check_eq("strobes off boundaries", bad_strobe, 0);
        check_eq("final empty underflow", int'(underflow), 1);

        // Mid-run disable with three entries queued.
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1;
            s_data = 8'(16 * i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_strobe(1100, cyc);
        check_eq("strobe found before disable", int'(cyc > 0), 1);
        check_eq("queued level", int'(fifo_level), 3);
        wait_neg(512);
        en = 1'b0;
        wait_neg(2);
        check_eq("disable pwm", int'(pwm_out), 0);
        check_eq("disable busy", int'(busy), 0);
        check_eq("disable level", int'(fifo_level), 3);
        check_eq("disable underflow kept", int'(underflow), 1);
        highs = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            highs += int'(pwm_out);
        end
        check_eq("disabled pwm stays low", highs, 0);

        // Re-enable pops immediately; then reset from RUN.
        en = 1'b1;
        wait_strobe(10, cyc);
        check_eq("reenable to strobe", cyc, 2);
        check_eq("reenable level", int'(fifo_level), 2);
        check_eq("reenable busy", int'(busy), 1);
        wait_neg(5);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("run reset");
        reset = 1'b0;
        en = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
